// File: rtl/vliw_regfile.sv
// Multi-lane 2R/1W-per-lane register file with pending scoreboard.
// Define VLIW_REGFILE_BYPASS_EN for same-cycle writeback-to-read bypass.
module vliw_regfile #(
  parameter int XLEN   = 64,
  parameter int NLANES = 2,
  parameter int NREGS  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2*NLANES*5-1:0]    ra,
  output logic [2*NLANES*XLEN-1:0] rd,
  input  logic [NLANES-1:0]        we,
  input  logic [NLANES*5-1:0]      wa,
  input  logic [NLANES*XLEN-1:0]   wd,
  input  logic [NLANES-1:0]        iss_v,
  input  logic [NLANES*5-1:0]      iss_rd,
  output logic [2*NLANES-1:0]      rdy,
  output logic                     wconf,
  output logic [5:0]               pend_cnt
);

  localparam int NP = 2 * NLANES;
  localparam int AW = $clog2(NREGS);
  localparam logic [5:0] NR = 6'(NREGS);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_n;
  logic [NLANES-1:0] wok;
  logic [NLANES-1:0] iok;
  logic             conf;
  logic [5:0]       cnt_n;

  function automatic logic inr(input logic [4:0] a);
    return ({1'b0, a} < NR);
  endfunction

  always_comb begin
    wok = '0;
    iok = '0;
    for (int l = 0; l < NLANES; l++) begin
      wok[l] = we[l] && (wa[5*l +: 5] != 5'd0)
               && inr(wa[5*l +: 5]);
      iok[l] = iss_v[l] && (iss_rd[5*l +: 5] != 5'd0)
               && inr(iss_rd[5*l +: 5]);
    end
  end

  always_comb begin
    conf = 1'b0;
    for (int i = 0; i < NLANES; i++)
      for (int j = i + 1; j < NLANES; j++)
        if (wok[i] && wok[j] && wa[5*i +: 5] == wa[5*j +: 5])
          conf = 1'b1;
  end

  // Issues are applied after writebacks so a new producer supersedes.
  always_comb begin
    pend_n = pend;
    for (int l = 0; l < NLANES; l++)
      if (wok[l])
        pend_n[wa[5*l +: AW]] = 1'b0;
    for (int l = 0; l < NLANES; l++)
      if (iok[l])
        pend_n[iss_rd[5*l +: AW]] = 1'b1;
    cnt_n = '0;
    for (int i = 0; i < NREGS; i++)
      cnt_n = cnt_n + 6'(pend_n[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      pend     <= '0;
      pend_cnt <= '0;
      wconf    <= 1'b0;
    end else begin
      for (int l = 0; l < NLANES; l++)
        if (wok[l])
          regs[wa[5*l +: AW]] <= wd[XLEN*l +: XLEN];
      pend     <= pend_n;
      pend_cnt <= cnt_n;
      if (conf)
        wconf <= 1'b1;
    end
  end

  always_comb begin
    rd  = '0;
    rdy = '1;
    for (int p = 0; p < NP; p++) begin
      if (inr(ra[5*p +: 5])) begin
        rd[XLEN*p +: XLEN] = regs[ra[5*p +: AW]];
        rdy[p] = ~pend[ra[5*p +: AW]];
`ifdef VLIW_REGFILE_BYPASS_EN
        if (reset)
          for (int l = 0; l < NLANES; l++)
            if (wok[l] && wa[5*l +: 5] == ra[5*p +: 5])
              rd[XLEN*p +: XLEN] = wd[XLEN*l +: XLEN];
`endif
      end
    end
  end

endmodule

// File: tb/tb_vliw_regfile.sv
// Randomized bench for vliw_regfile, NREGS=32 and NREGS=16 side by side.
// Reference model holds architectural registers as plain arrays.
module tb_vliw_regfile;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [19:0]  ra;
  logic [1:0]   we;
  logic [9:0]   wa;
  logic [127:0] wd;
  logic [1:0]   iss_v;
  logic [9:0]   iss_rd;

  logic [255:0] rd_a, rd_b;
  logic [3:0]   rdy_a, rdy_b;
  logic         wc_a, wc_b;
  logic [5:0]   pc_a, pc_b;

  int nchk = 0;
  int nerr = 0;

  logic [63:0] mreg  [2][32];
  bit          mpend [2][32];
  bit          mconf [2];
  int          nr    [2] = '{32, 16};

  vliw_regfile #(.XLEN(64), .NLANES(2), .NREGS(32)) u_dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd_a),
    .we(we), .wa(wa), .wd(wd), .iss_v(iss_v),
    .iss_rd(iss_rd), .rdy(rdy_a), .wconf(wc_a),
    .pend_cnt(pc_a)
  );

  vliw_regfile #(.XLEN(64), .NLANES(2), .NREGS(16)) u_dut_e (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd_b),
    .we(we), .wa(wa), .wd(wd), .iss_v(iss_v),
    .iss_rd(iss_rd), .rdy(rdy_b), .wconf(wc_b),
    .pend_cnt(pc_b)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit valid(int k, logic [4:0] a);
    return (a != 5'd0) && (int'(a) < nr[k]);
  endfunction

  function automatic logic [63:0] exp_rd(int k, logic [4:0] a);
    logic [63:0] v;
    v = (int'(a) < nr[k]) ? mreg[k][a] : 64'd0;
`ifdef VLIW_REGFILE_BYPASS_EN
    if (reset === 1'b1 && valid(k, a))
      for (int l = 0; l < 2; l++)
        if (we[l] && wa[5*l +: 5] == a)
          v = wd[64*l +: 64];
`endif
    return v;
  endfunction

  function automatic logic exp_rdy(int k, logic [4:0] a);
    if (int'(a) >= nr[k]) return 1'b1;
    return ~mpend[k][a];
  endfunction

  function automatic logic [5:0] exp_cnt(int k);
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(mpend[k][i]);
    return 6'(c);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      mconf[k] = 1'b0;
      for (int i = 0; i < 32; i++) begin
        mreg[k][i]  = '0;
        mpend[k][i] = 1'b0;
      end
    end
  endtask

  task automatic model_step();
    logic [4:0] a0, a1;
    if (!reset) return;
    a0 = wa[4:0];
    a1 = wa[9:5];
    for (int k = 0; k < 2; k++) begin
      if (we[0] && we[1] && a0 == a1 && valid(k, a0))
        mconf[k] = 1'b1;
      for (int l = 0; l < 2; l++)
        if (we[l] && valid(k, wa[5*l +: 5])) begin
          mreg[k][wa[5*l +: 5]]  = wd[64*l +: 64];
          mpend[k][wa[5*l +: 5]] = 1'b0;
        end
      for (int l = 0; l < 2; l++)
        if (iss_v[l] && valid(k, iss_rd[5*l +: 5]))
          mpend[k][iss_rd[5*l +: 5]] = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [255:0] rdv;
    logic [3:0]   ryv;
    logic [4:0]   a;
    for (int k = 0; k < 2; k++) begin
      rdv = k ? rd_b : rd_a;
      ryv = k ? rdy_b : rdy_a;
      for (int p = 0; p < 4; p++) begin
        a = ra[5*p +: 5];
        check($sformatf("%s.rd%0d.p%0d", tag, k, p),
              rdv[64*p +: 64], exp_rd(k, a));
        check($sformatf("%s.rdy%0d.p%0d", tag, k, p),
              64'(ryv[p]), 64'(exp_rdy(k, a)));
      end
      check($sformatf("%s.wconf%0d", tag, k),
            64'(k ? wc_b : wc_a), 64'(mconf[k]));
      check($sformatf("%s.cnt%0d", tag, k),
            64'(k ? pc_b : pc_a), 64'(exp_cnt(k)));
    end
  endtask

  task automatic tick(input string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    we = '0;
    iss_v = '0;
  endtask

  task automatic rand_in();
    ra = '0;
    for (int p = 0; p < 4; p++)
      ra[5*p +: 5] = 5'($urandom_range(0, 20));
    we = 2'($urandom);
    wa[4:0] = 5'($urandom_range(0, 20));
    wa[9:5] = ($urandom_range(0, 3) == 0) ? wa[4:0]
            : 5'($urandom_range(0, 20));
    wd = {$urandom, $urandom, $urandom, $urandom};
    iss_v = 2'($urandom_range(0, 3) == 0 ? 3 : $urandom_range(0, 1));
    iss_rd[4:0] = 5'($urandom_range(0, 20));
    iss_rd[9:5] = 5'($urandom_range(0, 20));
  endtask

  initial begin
    reset = 1'b0;
    ra = '0; we = '0; wa = '0; wd = '0;
    iss_v = '0; iss_rd = '0;
    model_clear();
    #1;
    for (int i = 0; i < 3; i++) begin
      rand_in();
      tick("rst");
    end
    reset = 1'b1;
    idle();
    ra = '0;
    ra[4:0] = 5'd5;
    tick("rel");

    we = 2'b01;
    wa = {5'd0, 5'd5};
    wd = {64'd0, 64'hDEADBEEF};
    tick("wr5");
    idle();
    tick("rd5");

    we = 2'b11;
    wa = {5'd20, 5'd0};
    wd = {64'h33, 64'hFF};
    iss_v = 2'b01;
    iss_rd = '0;
    ra = {5'd3, 5'd20, 5'd5, 5'd0};
    tick("x0oor");
    idle();
    tick("x0oor2");

    iss_v = 2'b10;
    iss_rd = {5'd9, 5'd0};
    ra = {5'd1, 5'd9, 5'd0, 5'd9};
    tick("iss9");
    idle();
    tick("pend9");
    we = 2'b01;
    wa = {5'd0, 5'd9};
    wd = {64'd0, 64'h5};
    tick("wr9");
    idle();
    tick("clr9");

    iss_v = 2'b01;
    iss_rd = {5'd0, 5'd9};
    tick("iss9b");
    we = 2'b01;
    wa = {5'd0, 5'd9};
    wd = {64'd0, 64'h6};
    iss_v = 2'b10;
    iss_rd = {5'd9, 5'd0};
    tick("setwin");
    idle();
    tick("setwin2");
    reset = 1'b0;
    #1;
    model_clear();
    check_all("arst");
    tick("arst2");
    reset = 1'b1;
    tick("rel2");

    we = 2'b11;
    wa = {5'd7, 5'd7};
    wd = {64'h22, 64'h11};
    ra = {5'd0, 5'd0, 5'd0, 5'd7};
    tick("conf");
    idle();
    for (int i = 0; i < 100; i++)
      tick("sticky");

    for (int i = 0; i < 400; i++) begin
      rand_in();
      tick("rnd");
    end
    idle();
    tick("end");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/vliw_regfile.md
Name: vliw_regfile

Overview:
- Multi-lane integer register file for the STARBUG VLIW configuration.
- Replaces the single-issue 2R/1W register file that the integer datapath drops when STARBUG is enabled.
- Provides 2 read ports and 1 write port per lane, plus a per-register pending scoreboard for long-latency producers.
- Sits between the decode-stage read addresses of all lanes and the writeback-stage results of all lanes.

Parameters:
- XLEN, 64, register data width.
- NLANES, 2, issue lanes; gives 2*NLANES read ports and NLANES write ports; legal range 1..4.
- NREGS, 32, architectural registers; 16 for RV32E/RV64E; legal values 16 and 32 only.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ra  in  2*NLANES*5  read addresses; port p is ra[5p+4:5p]; lane L owns ports 2L and 2L+1.
- rd  out  2*NLANES*XLEN  read data for port p, at rd[XLEN*p +: XLEN].
- we  in  NLANES  per-lane write enable (writeback stage).
- wa  in  NLANES*5  per-lane write address.
- wd  in  NLANES*XLEN  per-lane write data.
- iss_v  in  NLANES  per-lane issue of a long-latency producer (div, fcvt, load miss).
- iss_rd  in  NLANES*5  destination register of each issue.
- rdy  out  2*NLANES  port p reads a non-pending register.
- wconf  out  1  sticky flag: same-cycle multi-lane write conflict seen.
- pend_cnt  out  6  number of registers currently pending.

Behaviour:
- Storage: NREGS x XLEN flops.
  - Register 0 reads 0, ignores writes, and is never pending.
- Reset (reset=0), asynchronous:
  - All registers, pending bits, wconf and pend_cnt go to 0 immediately.
  - rd reads all 0 and rdy is all 1 while reset is held.
  - A reset mid-operation discards any in-flight pending state.
- Reads are combinational.
  - rd[p] = reg[ra[p]], with the bypass below when enabled.
  - If ra[p] >= NREGS, rd[p] = 0 and rdy[p] = 1.
- Writes take effect on the rising edge when we[L]=1, wa[L]!=0 and wa[L]<NREGS.
- Write conflict: two or more lanes write the same nonzero register in the same cycle.
  - The highest-numbered lane wins.
  - wconf sets to 1 at that edge and stays 1 until reset.
- Scoreboard, one pending bit per register, updated on the rising edge:
  - Set on iss_v[L]=1 with iss_rd[L] in 1..NREGS-1.
  - Cleared on an accepted write (we[L]=1) to that register.
  - Same register issued and written in the same cycle: set wins, so the bit stays 1 (new producer supersedes).
  - Multiple lanes issuing the same register: bit set once.
  - A write to a non-pending register is legal and leaves the bit at 0.
- rdy[p] = ~pending[ra[p]].
  - Combinational from the registered bits only; the same-cycle clear is not visible until the next cycle.
- pend_cnt is the registered popcount of the pending bits after each update; maximum NREGS-1 = 31.
- Latency:
  - Write-to-read: 1 cycle without bypass, 0 cycles with bypass.
  - Issue-to-rdy=0: 1 cycle.
  - Write-to-rdy=1: 1 cycle.

Optional Feature:
- Macro: VLIW_REGFILE_BYPASS_EN.
- Defined:
  - rd[p] returns wd of the highest lane with we=1 and wa==ra[p] (nonzero, <NREGS) in the same cycle; otherwise the stored value.
  - The bypass is combinational, wd to rd.
- Undefined:
  - rd returns only the stored value.
  - The same-cycle written value is visible from the next cycle.
- The scoreboard is unaffected by the macro.

Test Plan:
- Reset check: hold reset=0 three cycles with random inputs -> all rd=0, rdy all 1, pend_cnt=0, wconf=0; release, read x5 -> 0.
- Write then read: lane0 we, wa=5, wd=0xDEADBEEF; ra port0=5 the same cycle -> rd0=0xDEADBEEF with bypass, 0 without; next cycle -> 0xDEADBEEF in both builds.
- Write conflict: lane0 and lane1 both write x7 with 0x11 and 0x22 -> x7=0x22 next cycle, wconf=1 and stays 1 through 100 idle cycles.
- x0 and out-of-range: write x0=0xFF and iss_rd=0 -> read x0=0, pend_cnt=0; with NREGS=16, write x20=0x33 -> read x20=0, rdy=1, no other register changes.
- Scoreboard: issue x9 on lane1 -> next cycle rdy=0 for ports reading x9, pend_cnt=1; lane0 writes x9=0x5 -> next cycle rdy=1, pend_cnt=0, rd=0x5.
- Set-wins: with x9 pending, write x9 and issue x9 in the same cycle -> x9 stays pending, pend_cnt=1; assert reset mid-pending -> pend_cnt=0 and rdy=1 asynchronously.
